// File: rtl/pic_pkg.sv
// pic_pkg: shared constants, handshake state and priority ranking for the interrupt arbiter
package pic_pkg;
  localparam int NUM_IRQ = 8;
  localparam logic [2:0] SPURIOUS_IDX = 3'd7;
  typedef enum logic {IDLE, ACK1} ack_state_t;
  function automatic logic [2:0] prio_rank(input logic [2:0] idx, input logic [2:0] prio);
    return idx - prio;
  endfunction
endpackage

// File: rtl/pic_priority_select.sv
// pic_priority_select: rotating priority encoder, prio is the highest-priority position
module pic_priority_select import pic_pkg::*; (
  input  logic [NUM_IRQ-1:0] req,
  input  logic [2:0]         prio,
  output logic               found,
  output logic [2:0]         idx
);
  always_comb begin
    found = 1'b0;
    idx = 3'd0;
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      if (req[3'(prio + 3'(k))]) begin
        found = 1'b1;
        idx = 3'(prio + 3'(k));
      end
    end
  end
endmodule

// File: rtl/pic_irq_arbiter.sv
// pic_irq_arbiter: 8259A-style edge capture, fully nested priority, two-pulse INTA and EOI
module pic_irq_arbiter import pic_pkg::*; #(
  parameter int ROTATE = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   irq,
  input  logic [7:0]   pie,
  input  logic         gie,
  input  logic         inta,
  input  logic         eoi,
  input  logic [4:0]   vector_base,
  output logic         int_out,
  output logic [7:0]   vector,
  output logic         vector_valid,
  output logic [7:0]   irr,
  output logic [7:0]   isr
);
  ack_state_t state;
  logic [7:0] irq_q, cand, elig, w_mask, h_mask;
  logic [2:0] prio, idx, w_idx, h_idx;
  logic w_found, h_found, first, grant;
  assign cand = irr & pie;
  // only requests that outrank the highest in-service level may interrupt
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_IRQ; i++)
      elig[i] = cand[i] & (~h_found | (prio_rank(3'(i), prio) < prio_rank(h_idx, prio)));
  end
  pic_priority_select u_win (.req(elig), .prio(prio), .found(w_found), .idx(w_idx));
  pic_priority_select u_isr (.req(isr),  .prio(prio), .found(h_found), .idx(h_idx));
  assign first  = (state == IDLE) & inta;
  assign grant  = first & gie & w_found;
  assign w_mask = grant ? 8'b1 << w_idx : 8'h00;
  assign h_mask = (eoi & h_found) ? 8'b1 << h_idx : 8'h00;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      irq_q <= '0;
      irr <= '0;
      isr <= '0;
      prio <= '0;
      idx <= '0;
      int_out <= 1'b0;
      vector <= '0;
      vector_valid <= 1'b0;
    end else begin
      irq_q <= irq;
      irr <= (irr & ~w_mask) | (irq & ~irq_q);
      isr <= (isr & ~h_mask) | w_mask;
      int_out <= (state == IDLE) & ~inta & gie & |elig;
      vector_valid <= 1'b0;
      if (ROTATE != 0 && eoi && h_found)
        prio <= h_idx + 3'd1;
      if (first) begin
        idx <= grant ? w_idx : SPURIOUS_IDX;
        state <= ACK1;
      end else if (state == ACK1 && inta) begin
        vector <= {vector_base, idx};
        vector_valid <= 1'b1;
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_pic_irq_arbiter.sv
// tb_pic_irq_arbiter: scenario tasks for fixed (dut0) and rotating (dut1) arbiters, vector scoreboard
module tb_pic_irq_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] irq = '0, pie = 8'hFF;
  logic gie = 1'b1, inta = 1'b0, eoi = 1'b0;
  logic [4:0] vector_base = 5'h08;
  logic int_out0, vv0, int_out1, vv1;
  logic [7:0] vec0, irr0, isr0, vec1, irr1, isr1;
  logic [7:0] q0[$], q1[$];
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  pic_irq_arbiter #(.ROTATE(0)) dut0 (.clk(clk), .reset(reset), .irq(irq), .pie(pie), .gie(gie),
    .inta(inta), .eoi(eoi), .vector_base(vector_base), .int_out(int_out0), .vector(vec0),
    .vector_valid(vv0), .irr(irr0), .isr(isr0));
  pic_irq_arbiter #(.ROTATE(1)) dut1 (.clk(clk), .reset(reset), .irq(irq), .pie(pie), .gie(gie),
    .inta(inta), .eoi(eoi), .vector_base(vector_base), .int_out(int_out1), .vector(vec1),
    .vector_valid(vv1), .irr(irr1), .isr(isr1));

  always @(negedge clk) begin
    logic [7:0] e;
    if (vv0) begin
      checks++;
      if (q0.size() == 0) begin errors++; $display("FAIL vec0_unexpected got=%h", vec0); end
      else begin e = q0.pop_front(); if (vec0 !== e) begin errors++; $display("FAIL vec0 got=%h exp=%h", vec0, e); end end
    end
    if (vv1) begin
      checks++;
      if (q1.size() == 0) begin errors++; $display("FAIL vec1_unexpected got=%h", vec1); end
      else begin e = q1.pop_front(); if (vec1 !== e) begin errors++; $display("FAIL vec1 got=%h exp=%h", vec1, e); end end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; irq = '0; inta = 1'b0; eoi = 1'b0; pie = 8'hFF; gie = 1'b1;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic raise(input logic [7:0] r);
    irq = r; tick();
    irq = '0; tick();
  endtask

  task automatic ack(input logic [7:0] e0, input logic [7:0] e1);
    inta = 1'b1; tick();
    inta = 1'b0; tick();
    inta = 1'b1; q0.push_back(e0); q1.push_back(e1); tick();
    inta = 1'b0; tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({irr0, isr0, int_out0, vec0, vv0} !== 25'd0) begin errors++; $display("FAIL reset0 got=%h exp=0", {irr0, isr0, int_out0, vec0, vv0}); end
    checks++;
    if ({irr1, isr1, int_out1, vec1, vv1} !== 25'd0) begin errors++; $display("FAIL reset1 got=%h exp=0", {irr1, isr1, int_out1, vec1, vv1}); end
  endtask

  task automatic test_basic();
    do_reset();
    irq = 8'h08; tick();
    checks++; if (irr0 !== 8'h08) begin errors++; $display("FAIL basic_irr got=%h exp=08", irr0); end
    checks++; if (int_out0 !== 1'b0) begin errors++; $display("FAIL basic_int_early got=%b exp=0", int_out0); end
    irq = '0; tick();
    checks++; if (int_out0 !== 1'b1) begin errors++; $display("FAIL basic_int got=%b exp=1", int_out0); end
    inta = 1'b1; tick();
    checks++; if ({isr0, irr0, int_out0} !== {8'h08, 8'h00, 1'b0}) begin errors++; $display("FAIL basic_ack1 got=%h exp=%h", {isr0, irr0, int_out0}, {8'h08, 8'h00, 1'b0}); end
    inta = 1'b0; tick();
    inta = 1'b1; q0.push_back(8'h43); q1.push_back(8'h43); tick();
    checks++; if (vv0 !== 1'b1) begin errors++; $display("FAIL basic_vv_hi got=%b exp=1", vv0); end
    inta = 1'b0; tick();
    checks++; if (vv0 !== 1'b0) begin errors++; $display("FAIL basic_vv_lo got=%b exp=0", vv0); end
    tick(); tick();
    checks++; if (vec0 !== 8'h43) begin errors++; $display("FAIL basic_vec_hold got=%h exp=43", vec0); end
  endtask

  task automatic test_enables();
    do_reset();
    raise(8'h40);
    checks++; if (int_out0 !== 1'b1) begin errors++; $display("FAIL en_int got=%b exp=1", int_out0); end
    pie = 8'hBF; tick();
    checks++; if ({int_out0, irr0} !== {1'b0, 8'h40}) begin errors++; $display("FAIL en_pie_drop got=%h exp=%h", {int_out0, irr0}, {1'b0, 8'h40}); end
    pie = 8'hFF; gie = 1'b0; tick();
    checks++; if ({int_out0, irr0} !== {1'b0, 8'h40}) begin errors++; $display("FAIL en_gie_drop got=%h exp=%h", {int_out0, irr0}, {1'b0, 8'h40}); end
    gie = 1'b1; tick();
    checks++; if (int_out0 !== 1'b1) begin errors++; $display("FAIL en_restore got=%b exp=1", int_out0); end
  endtask

  task automatic test_fixed_priority();
    do_reset();
    raise(8'h24);
    ack(8'h42, 8'h42);
    checks++; if ({isr0, irr0, int_out0} !== {8'h04, 8'h20, 1'b0}) begin errors++; $display("FAIL fix_first got=%h exp=%h", {isr0, irr0, int_out0}, {8'h04, 8'h20, 1'b0}); end
    eoi = 1'b1; tick();
    eoi = 1'b0;
    checks++; if (isr0 !== 8'h00) begin errors++; $display("FAIL fix_eoi got=%h exp=00", isr0); end
    tick();
    checks++; if (int_out0 !== 1'b1) begin errors++; $display("FAIL fix_int_after_eoi got=%b exp=1", int_out0); end
    ack(8'h45, 8'h45);
    checks++; if ({isr0, irr0} !== {8'h20, 8'h00}) begin errors++; $display("FAIL fix_second got=%h exp=2000", {isr0, irr0}); end
  endtask

  task automatic test_nesting();
    do_reset();
    raise(8'h10);
    ack(8'h44, 8'h44);
    raise(8'h02);
    checks++; if (int_out0 !== 1'b1) begin errors++; $display("FAIL nest_int got=%b exp=1", int_out0); end
    ack(8'h41, 8'h41);
    checks++; if (isr0 !== 8'h12) begin errors++; $display("FAIL nest_isr got=%h exp=12", isr0); end
    eoi = 1'b1; tick();
    eoi = 1'b0;
    checks++; if (isr0 !== 8'h10) begin errors++; $display("FAIL nest_eoi got=%h exp=10", isr0); end
    checks++; if (isr1 !== 8'h10) begin errors++; $display("FAIL nest_eoi1 got=%h exp=10", isr1); end
  endtask

  task automatic test_spurious();
    do_reset();
    gie = 1'b0;
    raise(8'h01);
    checks++; if ({irr0, int_out0} !== {8'h01, 1'b0}) begin errors++; $display("FAIL spur_pend got=%h exp=%h", {irr0, int_out0}, {8'h01, 1'b0}); end
    ack(8'h47, 8'h47);
    checks++; if ({isr0, irr0} !== {8'h00, 8'h01}) begin errors++; $display("FAIL spur_state got=%h exp=0001", {isr0, irr0}); end
    gie = 1'b1;
  endtask

  task automatic test_rotate();
    do_reset();
    raise(8'h04);
    ack(8'h42, 8'h42);
    eoi = 1'b1; tick();
    eoi = 1'b0;
    raise(8'h11);
    checks++; if ({int_out0, int_out1} !== 2'b11) begin errors++; $display("FAIL rot_int got=%b exp=11", {int_out0, int_out1}); end
    inta = 1'b1; tick();
    inta = 1'b0;
    checks++; if (isr1 !== 8'h10) begin errors++; $display("FAIL rot_grant1 got=%h exp=10", isr1); end
    checks++; if (isr0 !== 8'h01) begin errors++; $display("FAIL rot_grant0 got=%h exp=01", isr0); end
    tick();
    inta = 1'b1; q0.push_back(8'h40); q1.push_back(8'h44); tick();
    inta = 1'b0; tick();
  endtask

  task automatic test_reset_mid_ack();
    do_reset();
    raise(8'h08);
    inta = 1'b1; tick();
    inta = 1'b0;
    reset = 1'b1; tick();
    reset = 1'b0;
    checks++; if ({irr0, isr0, int_out0} !== 17'd0) begin errors++; $display("FAIL rst_mid got=%h exp=0", {irr0, isr0, int_out0}); end
    inta = 1'b1; tick();
    inta = 1'b0;
    checks++; if ({vv0, vv1} !== 2'b00) begin errors++; $display("FAIL rst_mid_vv got=%b exp=00", {vv0, vv1}); end
    tick();
    checks++; if ({vv0, vv1} !== 2'b00) begin errors++; $display("FAIL rst_mid_vv2 got=%b exp=00", {vv0, vv1}); end
    inta = 1'b1; q0.push_back(8'h47); q1.push_back(8'h47); tick();
    inta = 1'b0; tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_enables();
    test_fixed_priority();
    test_nesting();
    test_spurious();
    test_rotate();
    test_reset_mid_ack();
    tick(); tick();
    checks++;
    if (q0.size() + q1.size() != 0) begin errors++; $display("FAIL missing_strobes got=%0d exp=0", q0.size() + q1.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
